// File: rtl/cpu_control_core.sv
// cpu_control_core: 8-bit accumulator CPU, bus-master side of the memory map.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   address      memory address (the MAR)
//   to_memory    store data, 0x00 outside the store state
//   write        one-cycle write strobe per store
//   from_memory  synchronous read data (one cycle after address)
//   ccr          condition flags {N,Z,V,C}
module cpu_control_core (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] address,
    output logic [7:0] to_memory,
    output logic       write,
    input  logic [7:0] from_memory,
    output logic [3:0] ccr
);

    localparam int unsigned W = 8;

    localparam logic [W-1:0] OP_LDA_IMM = 8'h86;
    localparam logic [W-1:0] OP_LDA_DIR = 8'h87;
    localparam logic [W-1:0] OP_LDB_IMM = 8'h88;
    localparam logic [W-1:0] OP_LDB_DIR = 8'h89;
    localparam logic [W-1:0] OP_STA_DIR = 8'h96;
    localparam logic [W-1:0] OP_STB_DIR = 8'h97;
    localparam logic [W-1:0] OP_ADD_AB  = 8'h42;
    localparam logic [W-1:0] OP_SUB_AB  = 8'h43;
    localparam logic [W-1:0] OP_BRA     = 8'h20;
    localparam logic [W-1:0] OP_BEQ     = 8'h23;

    typedef enum logic [3:0] {
        S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
        S_OP_MAR, S_OP_INC, S_LD_IMM, S_DIR_MAR,
        S_DIR_WAIT, S_LD_DIR, S_STORE, S_ALU,
        S_BR_MAR, S_BR_WAIT, S_BR_LOAD, S_BEQ_SKIP
    } state_t;

    state_t       state;
    logic [W-1:0] pc;
    logic [W-1:0] ir;
    logic [W-1:0] mar;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic [W:0]   sum9;
    logic [W:0]   diff9;
    logic [W-1:0] alu_res;
    logic         alu_v;
    logic         alu_c;
    logic [3:0]   alu_flags;

    assign address = mar;

    // ADD/SUB result and flags; ir[0] distinguishes SUB (0x43) from ADD (0x42)
    always_comb begin
        sum9  = {1'b0, a} + {1'b0, b};
        diff9 = {1'b0, a} - {1'b0, b};
        if (ir[0]) begin
            alu_res = diff9[W-1:0];
            alu_v   = (a[W-1] != b[W-1]) && (alu_res[W-1] != a[W-1]);
            alu_c   = diff9[W];
        end else begin
            alu_res = sum9[W-1:0];
            alu_v   = (a[W-1] == b[W-1]) && (alu_res[W-1] != a[W-1]);
            alu_c   = sum9[W];
        end
        alu_flags = {alu_res[W-1], (alu_res == '0), alu_v, alu_c};
    end

    // Instruction sequencer with registered bus outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH0;
            pc        <= '0;
            ir        <= '0;
            mar       <= '0;
            a         <= '0;
            b         <= '0;
            ccr       <= '0;
            write     <= 1'b0;
            to_memory <= '0;
        end else begin
            write     <= 1'b0;
            to_memory <= '0;
            case (state)
                S_FETCH0: begin
                    mar   <= pc;
                    state <= S_FETCH1;
                end
                S_FETCH1: begin
                    pc    <= pc + W'(1);
                    state <= S_FETCH2;
                end
                S_FETCH2: begin
                    ir    <= from_memory;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (ir)
                        OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR, OP_LDB_DIR,
                        OP_STA_DIR, OP_STB_DIR: state <= S_OP_MAR;
                        OP_ADD_AB, OP_SUB_AB:   state <= S_ALU;
                        OP_BRA:                 state <= S_BR_MAR;
                        OP_BEQ:                 state <= ccr[2] ? S_BR_MAR : S_BEQ_SKIP;
                        default:                state <= S_FETCH0;
                    endcase
                end
                S_OP_MAR: begin
                    mar   <= pc;
                    state <= S_OP_INC;
                end
                S_OP_INC: begin
                    pc <= pc + W'(1);
                    if (ir == OP_LDA_IMM || ir == OP_LDB_IMM) begin
                        state <= S_LD_IMM;
                    end else begin
                        state <= S_DIR_MAR;
                    end
                end
                S_LD_IMM: begin
                    if (ir == OP_LDA_IMM) a <= from_memory;
                    else                  b <= from_memory;
                    state <= S_FETCH0;
                end
                S_DIR_MAR: begin
                    mar <= from_memory;
                    // Stores raise the strobe so it is live during S_STORE
                    if (ir == OP_STA_DIR || ir == OP_STB_DIR) begin
                        write     <= 1'b1;
                        to_memory <= (ir == OP_STB_DIR) ? b : a;
                        state     <= S_STORE;
                    end else begin
                        state <= S_DIR_WAIT;
                    end
                end
                S_DIR_WAIT: state <= S_LD_DIR;
                S_LD_DIR: begin
                    if (ir == OP_LDA_DIR) a <= from_memory;
                    else                  b <= from_memory;
                    state <= S_FETCH0;
                end
                S_STORE: state <= S_FETCH0;
                S_ALU: begin
                    a     <= alu_res;
                    ccr   <= alu_flags;
                    state <= S_FETCH0;
                end
                S_BR_MAR: begin
                    mar   <= pc;
                    state <= S_BR_WAIT;
                end
                S_BR_WAIT: state <= S_BR_LOAD;
                S_BR_LOAD: begin
                    pc    <= from_memory;
                    state <= S_FETCH0;
                end
                S_BEQ_SKIP: begin
                    pc    <= pc + W'(1);
                    state <= S_FETCH0;
                end
                default: state <= S_FETCH0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_core.sv
// tb_cpu_control_core: self-checking bench with a synchronous memory model,
// table-driven ALU vectors, directed sequences and random programs checked
// against an instruction-level interpreter.
module tb_cpu_control_core;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] address;
    logic [7:0] to_memory;
    logic       write;
    logic [7:0] from_memory;
    logic [3:0] ccr;

    cpu_control_core dut (
        .clk(clk), .reset(reset), .address(address), .to_memory(to_memory),
        .write(write), .from_memory(from_memory), .ccr(ccr)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int k;

    logic [7:0] mem [256];
    logic [7:0] mm  [256];
    logic [7:0] ops [11];

    int         wq_state [$];
    logic [7:0] wq_addr  [$];
    logic [7:0] wq_data  [$];
    int         mq_state [$];
    logic [7:0] mq_addr  [$];
    logic [7:0] mq_data  [$];

    logic [7:0] m_pc, m_a, m_b;
    logic [3:0] m_ccr;
    int         m_states;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
        logic [3:0] flags;
    } alu_vec_t;

    alu_vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // One bus cycle: sample at negedge, read-before-write RAM, data valid next cycle
    task automatic tick();
        logic [7:0] rd;
        @(negedge clk);
        k++;
        rd = mem[address];
        if (write === 1'b1) begin
            mem[address] = to_memory;
            wq_state.push_back(k);
            wq_addr.push_back(address);
            wq_data.push_back(to_memory);
        end
        @(posedge clk);
        #1 from_memory = rd;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic start();
        reset = 1'b0;
        #2;
        wq_state.delete(); wq_addr.delete(); wq_data.delete();
        k = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        from_memory = 8'h00;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Instruction-level interpreter over mm[]
    task automatic model_run(input int n_instr);
        logic [7:0] pc, a, b, op, ad, r;
        logic [3:0] f;
        int st, sa, sb, sr;
        logic add_c;
        pc = 0; a = 0; b = 0; f = 0; st = 0;
        mq_state.delete(); mq_addr.delete(); mq_data.delete();
        for (int n = 0; n < n_instr; n++) begin
            op = mm[pc]; pc = pc + 8'd1; st += 4;
            case (op)
                8'h86, 8'h88: begin
                    if (op == 8'h86) a = mm[pc]; else b = mm[pc];
                    pc = pc + 8'd1; st += 3;
                end
                8'h87, 8'h89: begin
                    ad = mm[pc]; pc = pc + 8'd1; st += 5;
                    if (op == 8'h87) a = mm[ad]; else b = mm[ad];
                end
                8'h96, 8'h97: begin
                    ad = mm[pc]; pc = pc + 8'd1; st += 4;
                    r = (op == 8'h96) ? a : b;
                    mm[ad] = r;
                    mq_state.push_back(st); mq_addr.push_back(ad); mq_data.push_back(r);
                end
                8'h42, 8'h43: begin
                    sa = (a > 8'd127) ? int'(a) - 256 : int'(a);
                    sb = (b > 8'd127) ? int'(b) - 256 : int'(b);
                    if (op == 8'h42) begin
                        sr = sa + sb;
                        add_c = (int'(a) + int'(b)) > 255;
                        r = a + b;
                    end else begin
                        sr = sa - sb;
                        add_c = a < b;
                        r = a - b;
                    end
                    f = {r[7], r == 8'h00, (sr > 127) || (sr < -128), add_c};
                    a = r; st += 1;
                end
                8'h20: begin
                    pc = mm[pc]; st += 3;
                end
                8'h23: begin
                    if (f[2]) begin pc = mm[pc]; st += 3; end
                    else begin pc = pc + 8'd1; st += 1; end
                end
                default: ;
            endcase
        end
        m_pc = pc; m_a = a; m_b = b; m_ccr = f; m_states = st;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        ops = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43, 8'h20, 8'h23, 8'h01};
        vecs[0] = '{8'h7F, 8'h01, 8'h42, 8'h80, 4'b1010};
        vecs[1] = '{8'hFF, 8'h01, 8'h42, 8'h00, 4'b0101};
        vecs[2] = '{8'h80, 8'h80, 8'h42, 8'h00, 4'b0111};
        vecs[3] = '{8'h10, 8'h20, 8'h42, 8'h30, 4'b0000};
        vecs[4] = '{8'h05, 8'h05, 8'h43, 8'h00, 4'b0100};
        vecs[5] = '{8'h05, 8'h04, 8'h43, 8'h01, 4'b0000};
        vecs[6] = '{8'h00, 8'h01, 8'h43, 8'hFF, 4'b1001};
        vecs[7] = '{8'h80, 8'h01, 8'h43, 8'h7F, 4'b0010};
        vecs[8] = '{8'h7F, 8'hFF, 8'h43, 8'h80, 4'b1011};
        from_memory = 8'h00;
        reset = 1'b0;
        clear_mem();
        #12;

        // Reset state
        check("rst_address", 32'(address), 32'h0);
        check("rst_write", 32'(write), 32'h0);
        check("rst_to_memory", 32'(to_memory), 32'h0);
        check("rst_ccr", 32'(ccr), 32'h0);
        check("rst_pc", 32'(dut.pc), 32'h0);
        check("rst_a", 32'(dut.a), 32'h0);

        // LDA #AA; STA E0: single write in state 15
        clear_mem();
        mem[0] = 8'h86; mem[1] = 8'hAA; mem[2] = 8'h96; mem[3] = 8'hE0;
        start();
        ticks(16);
        check("st_count", 32'(wq_state.size()), 32'd1);
        if (wq_state.size() > 0) begin
            check("st_state", 32'(wq_state[0]), 32'd15);
            check("st_addr", 32'(wq_addr[0]), 32'hE0);
            check("st_data", 32'(wq_data[0]), 32'hAA);
        end
        start();
        ticks(15);
        check("st_pc", 32'(dut.pc), 32'h04);
        check("st_mem", 32'(mem[8'hE0]), 32'hAA);

        // ALU vectors
        for (int v = 0; v < 9; v++) begin
            clear_mem();
            mem[0] = 8'h86; mem[1] = vecs[v].a; mem[2] = 8'h88; mem[3] = vecs[v].b;
            mem[4] = vecs[v].op;
            start();
            ticks(19);
            check($sformatf("alu%0d_a", v), 32'(dut.a), 32'(vecs[v].res));
            check($sformatf("alu%0d_ccr", v), 32'(ccr), 32'(vecs[v].flags));
        end

        // BEQ taken (A-B=0) and not taken (A-B=1)
        for (int t = 0; t < 2; t++) begin
            clear_mem();
            mem[0] = 8'h86; mem[1] = 8'h05; mem[2] = 8'h88; mem[3] = (t == 0) ? 8'h05 : 8'h04;
            mem[4] = 8'h43; mem[5] = 8'h23; mem[6] = 8'h20; mem[8'h20] = 8'h01;
            start();
            ticks((t == 0) ? 26 : 24);
            check($sformatf("beq%0d_pc", t), 32'(dut.pc), (t == 0) ? 32'h20 : 32'h07);
            check($sformatf("beq%0d_a", t), 32'(dut.a), (t == 0) ? 32'h00 : 32'h01);
            check($sformatf("beq%0d_z", t), 32'(ccr[2]), (t == 0) ? 32'h1 : 32'h0);
        end

        // LDA_DIR sweep across the I/O ports
        for (int p = 0; p < 16; p++) begin
            clear_mem();
            mem[0] = 8'h87; mem[1] = 8'hF0 + 8'(p);
            mem[8'hF0 + 8'(p)] = 8'h50 + 8'(4 * p);
            start();
            ticks(9);
            check($sformatf("lddir_%0h", 8'hF0 + 8'(p)), 32'(dut.a), 32'(8'h50 + 8'(4 * p)));
        end
        check("lddir_ccr", 32'(ccr), 32'h0);

        // Reset asserted during the store state
        clear_mem();
        mem[0] = 8'h86; mem[1] = 8'hAA; mem[2] = 8'h96; mem[3] = 8'hE0;
        start();
        ticks(14);
        @(negedge clk);
        check("mid_write_hi", 32'(write), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("mid_write", 32'(write), 32'h0);
        check("mid_to_memory", 32'(to_memory), 32'h0);
        check("mid_address", 32'(address), 32'h0);
        check("mid_pc", 32'(dut.pc), 32'h0);
        check("mid_ir", 32'(dut.ir), 32'h0);
        check("mid_a", 32'(dut.a), 32'h0);
        check("mid_b", 32'(dut.b), 32'h0);
        check("mid_ccr", 32'(ccr), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        k = 0;
        wq_state.delete(); wq_addr.delete(); wq_data.delete();
        ticks(2);
        check("restart_addr", 32'(address), 32'h0);
        check("restart_pc", 32'(dut.pc), 32'h1);
        ticks(5);
        check("restart_a", 32'(dut.a), 32'hAA);
        check("restart_nowrite", 32'(wq_state.size()), 32'd0);

        // Random programs against the interpreter
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom);
                if ($urandom_range(1, 0) == 1) mem[i] = ops[$urandom_range(10, 0)];
            end
            for (int i = 0; i < 256; i++) mm[i] = mem[i];
            model_run(14);
            start();
            ticks(m_states);
            check($sformatf("rnd%0d_wcount", t), 32'(wq_state.size()), 32'(mq_state.size()));
            for (int i = 0; i < mq_state.size() && i < wq_state.size(); i++) begin
                check($sformatf("rnd%0d_w%0d_state", t, i), 32'(wq_state[i]), 32'(mq_state[i]));
                check($sformatf("rnd%0d_w%0d_addr", t, i), 32'(wq_addr[i]), 32'(mq_addr[i]));
                check($sformatf("rnd%0d_w%0d_data", t, i), 32'(wq_data[i]), 32'(mq_data[i]));
            end
            check($sformatf("rnd%0d_pc", t), 32'(dut.pc), 32'(m_pc));
            check($sformatf("rnd%0d_a", t), 32'(dut.a), 32'(m_a));
            check($sformatf("rnd%0d_b", t), 32'(dut.b), 32'(m_b));
            check($sformatf("rnd%0d_ccr", t), 32'(ccr), 32'(m_ccr));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
